fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Instruction-fetch front end. Owns the program counter, drives the word address into the synchronous instruction memory (`intMem`) and turns its one-cycle-latency read data into a valid/ready instruction stream for the decode stage. Handles decode backpressure without losing or duplicating instructions, and redirects on taken branches and jumps. Sits directly upstream of `intMem` and between `intMem` and decode.

## Interface
Parameters:
- `MEM_WIDTH`, default 64: instruction memory depth in words; must be a power of two.
- `RESET_PC`, default 0: word address fetched first after reset.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  out  32  word index to `intMem`; a register output, with no combinational path from any input.
- `instruction`  in  32  `intMem` read data; it equals mem[`address`] as sampled at the previous edge.
- `redirect`  in  1  taken branch or jump; has priority over every other event.
- `redirect_target`  in  32  word address of the new fetch target; only its low log2(`MEM_WIDTH`) bits are used.
- `out_valid`  out  1  decode-side valid.
- `out_ready`  in  1  decode-side ready.
- `out_instruction`  out  32  instruction word.
- `out_pc`  out  32  word address of `out_instruction`, zero-extended.

## Operation
Registers:
- `pc_q`: next address to issue; drives `address`.
- `infl_v`, `infl_pc`: read in flight. Its data is the `instruction` input in the current cycle.
- `skid_v`, `skid_pc`, `skid_instr`: one-entry skid buffer.

Definitions:
- fire = `out_valid` & `out_ready`.
- issue: `infl_v`<=1, `infl_pc`<=`pc_q`, `pc_q`<=`pc_q`+1 mod `MEM_WIDTH`.

Output selection:
- If `skid_v`, present the skid buffer.
- Otherwise, if `infl_v`, present `instruction` with `infl_pc`.
- `out_valid` = `skid_v` | `infl_v`.

States are encoded by {`skid_v`, `infl_v`}:
- EMPTY {0,0}: issue; go to STREAM.
- STREAM {0,1}:
  - fire: issue; stay in STREAM.
  - no fire: capture `instruction`/`infl_pc` into the skid buffer, issue; go to FULL.
- FULL {1,1}:
  - fire: skid <= `instruction`/`infl_pc`, issue; stay in FULL.
  - no fire: drop the in-flight read, `pc_q`<=`infl_pc` (replay it), `infl_v`<=0; go to REPLAY.
- REPLAY {1,0}:
  - fire: issue; go to STREAM.
  - no fire: issue; go to FULL.

Redirect:
- Any state with `redirect`=1: `pc_q`<=target mod `MEM_WIDTH`, `infl_v`<=0, `skid_v`<=0; go to EMPTY.
- A handshake in the redirect cycle counts as completed from decode's side. Fetch discards all buffered state regardless.

Arithmetic:
- PC is held in log2(`MEM_WIDTH`) bits.
- Increments wrap from `MEM_WIDTH`-1 to 0.
- `address` and `out_pc` are zero-extended to 32 bits.

Outputs must stay stable while `out_valid`=1 and `out_ready`=0, except under redirect or reset.

## Timing
- Reset (asynchronous, immediate): `pc_q`=`RESET_PC`, `infl_v`=0, `skid_v`=0. Therefore `address`=`RESET_PC`, `out_valid`=0, and `out_pc`/`out_instruction` are don't-care (must not be X-propagated into `out_valid`).
- First edge after reset release issues `RESET_PC`. `out_valid`=1 with mem[`RESET_PC`] after that edge, i.e. 1-cycle latency.
- Steady state with `out_ready`=1: one instruction per cycle.
- Redirect sampled at edge e: `out_valid`=0 for exactly one cycle after e. The target instruction is valid after edge e+1.
- A stall never loses an instruction. A single stall cycle costs at most one replay bubble after release; stalls lasting more than one cycle alternate FULL and REPLAY.
- `intMem` has no reset. Its stale output is masked by `infl_v`=0.

## Structure
- Shared package holds:
  - the `fetch_state_t` encoding (EMPTY, STREAM, FULL, REPLAY);
  - the `MEM_WIDTH` default;
  - the PC index width constant, log2(`MEM_WIDTH`).
- One sub-module, `fetch_skid_buf`: the one-entry pc+instruction buffer with load/clear and async reset.
- The PC, in-flight tracking and redirect logic stay in `fetch_pc_unit`.

## Test plan
- Reset release, `out_ready`=1, mem[i]=i+100: `out_pc` 0,1,2,3… on consecutive cycles with instructions 100,101,102…; first valid one cycle after release.
- `out_ready` low for 3 cycles while `out_pc`=5: outputs hold pc 5/105. After release the sequence is 5,6,7… with no gap in pcs and no duplicates.
- Redirect to 20 while streaming at pc 8: exactly one cycle with `out_valid`=0, then pc 20/120, 21/121.
- Wrap: redirect to 62 gives pcs 62,63,0. Redirect target 70 fetches pc 6.
- Async reset asserted in FULL: `out_valid`=0 and `address`=`RESET_PC` before the next clock edge. After release, fetching restarts at `RESET_PC`.
- Random `out_ready` with redirects, including a redirect during a stall: the accepted pc/instruction stream matches a reference PC model exactly.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: state encoding
// and the default memory geometry.
package fetch_pc_unit_pkg;

    localparam int MEM_WIDTH_DEFAULT = 64;
    localparam int PC_IDX_W          = $clog2(MEM_WIDTH_DEFAULT);

    // Encoding is {skid_v, infl_v}; the state is never stored separately.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        STREAM = 2'b01,
        REPLAY = 2'b10,
        FULL   = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_skid_buf.sv
// One-entry pc+instruction holding buffer used when decode stalls.
module fetch_skid_buf
    import fetch_pc_unit_pkg::*;
#(
    parameter int PCW = PC_IDX_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic           clear_i,
    input  logic [PCW-1:0] pc_i,
    input  logic [31:0]    instr_i,
    output logic           valid_o,
    output logic [PCW-1:0] pc_o,
    output logic [31:0]    instr_o
);

    logic           valid_q;
    logic [PCW-1:0] pc_q;
    logic [31:0]    instr_q;

    // Clear wins over load so a redirect always empties the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the PC, tracks the one read in flight to intMem and
// presents a valid/ready instruction stream to decode.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int          MEM_WIDTH = MEM_WIDTH_DEFAULT,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] address,
    input  logic [31:0] instruction,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
);

    localparam int             PCW       = $clog2(MEM_WIDTH);
    localparam logic [PCW-1:0] RESET_IDX = RESET_PC[PCW-1:0];

    logic [PCW-1:0] pc_q, pc_d;
    logic           infl_v_q, infl_v_d;
    logic [PCW-1:0] infl_pc_q, infl_pc_d;

    logic           skid_v;
    logic [PCW-1:0] skid_pc;
    logic [31:0]    skid_instr;
    logic           skid_load;
    logic           skid_clear;

    logic           fire;
    logic           issue;
    fetch_state_t   state;

    logic           unused_target_bits;
    assign unused_target_bits = ^redirect_target[31:PCW];

    assign state = fetch_state_t'({skid_v, infl_v_q});
    assign fire  = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_IDX;
            infl_v_q  <= 1'b0;
            infl_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            infl_v_q  <= infl_v_d;
            infl_pc_q <= infl_pc_d;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        infl_v_d   = infl_v_q;
        infl_pc_d  = infl_pc_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        issue      = 1'b0;

        if (redirect) begin
            pc_d       = redirect_target[PCW-1:0];
            infl_v_d   = 1'b0;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    issue = 1'b1;
                end
                STREAM: begin
                    skid_load = ~fire;
                    issue     = 1'b1;
                end
                FULL: begin
                    if (fire) begin
                        skid_load = 1'b1;
                        issue     = 1'b1;
                    end else begin
                        // Buffer is occupied, so the arriving word cannot be
                        // kept; refetch it once decode drains the buffer.
                        pc_d     = infl_pc_q;
                        infl_v_d = 1'b0;
                    end
                end
                REPLAY: begin
                    skid_clear = fire;
                    issue      = 1'b1;
                end
                default: begin
                    issue = 1'b0;
                end
            endcase

            if (issue) begin
                infl_v_d  = 1'b1;
                infl_pc_d = pc_q;
                pc_d      = pc_q + 1'b1;
            end
        end
    end

    fetch_skid_buf #(
        .PCW(PCW)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (infl_pc_q),
        .instr_i (instruction),
        .valid_o (skid_v),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    assign address         = 32'(pc_q);
    assign out_valid       = skid_v | infl_v_q;
    assign out_instruction = skid_v ? skid_instr : instruction;
    assign out_pc          = skid_v ? 32'(skid_pc) : 32'(infl_pc_q);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus a reference model of the
// accepted instruction stream checked every cycle.
module tb_fetch_pc_unit;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    logic [31:0] mem [DEPTH];

    int tests_run = 0;
    int fail_cnt  = 0;
    int accepted  = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.MEM_WIDTH(DEPTH), .RESET_PC(32'd0)) dut (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .instruction     (instruction),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc)
    );

    // Synchronous instruction memory with one cycle of read latency, no reset.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i + 100);
    end
    always @(posedge clk) instruction <= mem[address[5:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decode must see pcs in program order from the reset
    // or redirect target, one past the last accepted word, each with mem[pc].
    int          exp_pc = 0;
    bit          prev_redir = 0, prev2_redir = 0, prev_stall = 0;
    logic [31:0] held_pc, held_instr;

    always @(negedge clk) begin
        if (reset) begin
            exp_pc      = 0;
            prev_redir  = 0;
            prev2_redir = 0;
            prev_stall  = 0;
        end else begin
            if (prev_redir)
                check("redirect_bubble", 32'(out_valid), 32'd0);
            else if (prev2_redir)
                check("redirect_resume", 32'(out_valid), 32'd1);
            if (prev_stall) begin
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                check("stall_hold_pc", out_pc, held_pc);
                check("stall_hold_instr", out_instruction, held_instr);
            end
            if (out_valid === 1'b1 && out_ready) begin
                $display("[TB] accept pc=%0d instr=%0d", out_pc, out_instruction);
                check("stream_pc", out_pc, 32'(exp_pc));
                check("stream_instr", out_instruction, mem[exp_pc]);
                exp_pc = (exp_pc + 1) % DEPTH;
                accepted++;
            end
            if (redirect) exp_pc = int'(redirect_target % DEPTH);
            prev2_redir = prev_redir;
            prev_redir  = redirect;
            prev_stall  = (out_valid === 1'b1) && !out_ready && !redirect;
            held_pc     = out_pc;
            held_instr  = out_instruction;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string name, input int pc);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_pc"}, out_pc, 32'(pc));
        check({name, "_instr"}, out_instruction, 32'(pc + 100));
    endtask

    // Advance to the next cycle showing a valid word, tolerating replay bubbles.
    task automatic next_valid(input string name);
        int n = 0;
        tick();
        while (out_valid !== 1'b1 && n < 5) begin
            tick();
            n++;
        end
        if (out_valid !== 1'b1) begin
            tests_run++;
            fail_cnt++;
            $display("[TB] FAIL %s: no valid word within bound", name);
        end
    endtask

    initial begin
        int acc_start;
        reset           = 1'b1;
        out_ready       = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_address", address, 32'd0);

        // Streaming from reset, one word per cycle.
        reset     = 1'b0;
        out_ready = 1'b1;
        check("release_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i <= 5; i++) begin
            tick();
            expect_word("stream", i);
        end

        // Three-cycle stall at pc 5.
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            expect_word("stall", 5);
        end
        out_ready = 1'b1;
        next_valid("after_stall");
        check("after_stall_pc", out_pc, 32'd6);
        next_valid("after_stall");
        check("after_stall_pc", out_pc, 32'd7);
        next_valid("after_stall");
        check("after_stall_pc", out_pc, 32'd8);

        // Redirect to 20 while pc 8 is on the output.
        redirect        = 1'b1;
        redirect_target = 32'd20;
        tick();
        redirect = 1'b0;
        check("redir20_bubble", 32'(out_valid), 32'd0);
        tick();
        expect_word("redir20", 20);
        tick();
        expect_word("redir20", 21);

        // Wrap past the top of memory.
        redirect        = 1'b1;
        redirect_target = 32'd62;
        tick();
        redirect = 1'b0;
        check("redir62_bubble", 32'(out_valid), 32'd0);
        tick();
        expect_word("wrap", 62);
        tick();
        expect_word("wrap", 63);
        tick();
        expect_word("wrap", 0);

        // Out-of-range target keeps only the index bits: 70 -> 6.
        redirect        = 1'b1;
        redirect_target = 32'd70;
        tick();
        redirect = 1'b0;
        check("redir70_bubble", 32'(out_valid), 32'd0);
        tick();
        expect_word("redir70", 6);

        // Stall into FULL, then assert reset asynchronously mid-cycle.
        out_ready = 1'b0;
        tick();
        expect_word("full_hold", 6);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_address", address, 32'd0);
        tick();
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        expect_word("restart", 0);

        // Redirect taken while decode is stalled.
        out_ready = 1'b0;
        tick();
        tick();
        redirect        = 1'b1;
        redirect_target = 32'd40;
        tick();
        redirect  = 1'b0;
        out_ready = 1'b1;
        check("stall_redir_bubble", 32'(out_valid), 32'd0);
        tick();
        expect_word("stall_redir", 40);

        // Random backpressure with isolated redirects; the model checks it all.
        acc_start = accepted;
        for (int c = 0; c < 400; c++) begin
            tick();
            out_ready       = ($urandom_range(0, 3) != 0);
            redirect        = !redirect && ($urandom_range(0, 19) == 0);
            redirect_target = 32'($urandom_range(0, 127));
        end
        redirect  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tests_run++;
        if (accepted - acc_start < 100) begin
            fail_cnt++;
            $display("[TB] FAIL random_throughput: got %0d accepted, expected at least 100",
                     accepted - acc_start);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
